fir_mac_filter: RTL and testbench
=================================

# fir_mac_filter

Parametrised, time-multiplexed FIR filter for the signal-processing chain. It is the successor to the fixed low-pass FIR and sits between the function-generator mixer and downstream analysis. It adds configurable tap count, widths and runtime-loadable coefficient banks, so one instance serves as LPF, HPF or BPF. One shared multiply-accumulate unit computes one tap per clock after each sample strobe, then rounds and saturates the result to the input width.

## Interface
- `DW`, 12: signed sample width (`din`/`dout`).
- `CW`, 16: signed coefficient width, Q1.(CW-1).
- `TAPS`, 32: number of taps (≥2).
- `NBANK`, 2: number of coefficient banks (≥1).
- `clk` input, 1: system clock.
- `rst` input, 1: synchronous reset, active-high.
- `f_s` input, 1: sample clock/strobe, asynchronous to `clk`, one rising edge per sample.
- `din` input, DW: signed input sample.
- `bank_sel` input, clog2(NBANK): active coefficient bank for the next sample.
- `coef_we` input, 1: coefficient write enable.
- `coef_bank` input, clog2(NBANK): bank to write.
- `coef_addr` input, clog2(TAPS): tap index to write.
- `coef_data` input, CW: signed coefficient value.
- `dout` output, DW: signed filtered sample, held between updates.
- `dout_valid` output, 1: one-cycle pulse when `dout` updates.
- `busy` output, 1: high while a sample is being computed.
- `coef_nack` output, 1: one-cycle pulse when a coefficient write is rejected.
- `overrun` output, 1: sticky; an `f_s` edge arrived while busy.

## Operation
- `f_s` passes through a 2-flop synchronizer, then a rising-edge detector. `rise` is true for one cycle.
- FSM states: IDLE, MAC, OUT.
  - IDLE + `rise`: write `din` to the delay line at `wr_ptr`, latch `bank_sel` as `act_bank`, clear acc, set `k`=0, go to MAC.
  - MAC: `acc += x[wr_ptr-k mod TAPS] * c[act_bank][k]`. At `k`=TAPS-1 go to OUT, else `k`++.
  - OUT: `dout` = sat_DW((acc + 2^(CW-2)) >>> (CW-1)), pulse `dout_valid`, `wr_ptr`++ mod TAPS, go to IDLE.
- Accumulator width is DW+CW+clog2(TAPS). It never wraps internally; saturation to [-2^(DW-1), 2^(DW-1)-1] happens only in OUT.
- Delay line is circular. `wr_ptr` wraps from TAPS-1 to 0, and tap index arithmetic is modulo TAPS.
- Overrun: a `rise` seen in MAC or OUT is dropped (not captured) and sets `overrun`. Only `rst` clears it.
- Coefficient writes:
  - Accepted in any state, except a write to `act_bank` while `busy`=1.
  - A rejected write is dropped and pulses `coef_nack` the next cycle.
  - An out-of-range `coef_bank` or `coef_addr` (non-power-of-two parameters) is also rejected with `coef_nack`.
- A `bank_sel` change takes effect on the next captured sample. A computation in progress is unaffected.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `coef_nack`=0, `overrun`=0, state IDLE, `wr_ptr`=0. All delay-line entries and all coefficients are 0 (registers, not RAM).
- Latency: `f_s` rising edge → `rise` after 2–3 `clk` cycles. From the `rise` cycle C:
  - capture at the end of C;
  - `busy` is high from C+1 through C+TAPS+1;
  - `dout`/`dout_valid` register at the end of C+TAPS+1 and are visible in C+TAPS+2.
- `din` must be stable in the `rise` cycle. Minimum `f_s` period is TAPS+2 `clk` cycles plus synchronizer margin.
- A coefficient write takes effect in the cycle after `coef_we`. A write and a MAC read of the same non-active-bank entry in the same cycle need no forwarding.
- `rst` during MAC or OUT aborts the computation, produces no `dout_valid`, and restores all reset values the next cycle.
- `rise` and `rst` in the same cycle: reset wins.

## Structure
- Package `fir_pkg`:
  - FSM state enum (IDLE/MAC/OUT);
  - `clog2` function;
  - accumulator-width and round/shift constants derived from DW/CW/TAPS;
  - saturation function.
- Sub-module `fir_coef_bank`: an NBANK×TAPS×CW register file with one write port (bank, addr, data, we) and a combinational read by (bank, index). It resets to zero.
- The top level contains the synchronizer, edge detect, FSM, delay line, MAC and output stage.

## Test plan
- Impulse: bank0 = c[k]=k*100, then `din`=+2047 for one sample and 0 after. `dout` sequence equals round(2047*k*100/32768) for k=0..31, then 0.
- DC step, LPF bank: all coefficients 1024 (Σ=32768), constant `din`=1000. `dout` ramps and settles at 1000 after 32 samples.
- Saturation: all coefficients 32767, `din`=+2047. `dout`=2047. With `din`=-2048, `dout`=-2048.
- Bank switch and nack:
  - load bank1 as the negated bank0;
  - toggle `bank_sel` mid-MAC, and check the current output still uses bank0 while the next uses bank1;
  - write to `act_bank` while busy, and check `coef_nack`=1 and the coefficient is unchanged.
- Overrun: `f_s` edges 10 `clk` cycles apart with TAPS=32. The second sample is dropped and `overrun`=1 stays set, with `dout_valid` pulsing once.
- Reset mid-MAC: assert `rst` at C+10. There is no `dout_valid`, all outputs return to 0, and the next impulse reproduces the clean impulse response.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  // Never returns less than 1 so that single-entry selects still get a 1-bit port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic int unsigned out_shift(input int unsigned cw);
    return cw - 1;
  endfunction

  function automatic longint round_const(input int unsigned cw);
    return longint'(1) <<< (cw - 2);
  endfunction

  function automatic longint sat(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NBANK x TAPS coefficient register file: one write port, combinational read.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int CW    = 16,
  parameter int TAPS  = 32,
  parameter int NBANK = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [clog2(NBANK)-1:0]     wr_bank,
  input  logic [clog2(TAPS)-1:0]      wr_addr,
  input  logic signed [CW-1:0]        wr_data,
  input  logic [clog2(NBANK)-1:0]     rd_bank,
  input  logic [clog2(TAPS)-1:0]      rd_idx,
  output logic signed [CW-1:0]        rd_data
);

  logic signed [CW-1:0] mem_q [NBANK][TAPS];
  logic signed [CW-1:0] mem_d [NBANK][TAPS];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(wr_bank) < NBANK) && (32'(wr_addr) < TAPS)) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = ((32'(rd_bank) < NBANK) && (32'(rd_idx) < TAPS)) ? mem_q[rd_bank][rd_idx] : '0;

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one shared MAC computes one tap per clock after each f_s strobe.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int DW    = 12,
  parameter int CW    = 16,
  parameter int TAPS  = 32,
  parameter int NBANK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_s,
  input  logic signed [DW-1:0]     din,
  input  logic [clog2(NBANK)-1:0]  bank_sel,
  input  logic                     coef_we,
  input  logic [clog2(NBANK)-1:0]  coef_bank,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]     coef_data,
  output logic signed [DW-1:0]     dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     coef_nack,
  output logic                     overrun
);

  localparam int BW   = clog2(NBANK);
  localparam int AW   = clog2(TAPS);
  localparam int ACCW = acc_width(DW, CW, TAPS);
  localparam int SH   = out_shift(CW);
  localparam logic signed [ACCW:0] RND = (ACCW + 1)'(round_const(CW));

  logic fs_meta_q, fs_sync_q, fs_prev_q, rise;

  state_e                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]          act_bank_q, act_bank_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   dline_q [TAPS];
  logic signed [DW-1:0]   dline_d [TAPS];
  logic signed [DW-1:0]   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   coef_nack_q, coef_nack_d;
  logic                   overrun_q, overrun_d;

  logic                   coef_rej;
  logic [AW:0]            idx_sum;
  logic [AW-1:0]          tap_idx;
  logic signed [CW-1:0]   coef_rd;
  logic signed [DW-1:0]   x_tap;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW:0]   rnd_sum, shifted;

  assign rise = fs_sync_q & ~fs_prev_q;
  assign busy = (state_q != IDLE);

  assign coef_rej = (busy && (coef_bank == act_bank_q)) ||
                    (32'(coef_bank) >= NBANK) || (32'(coef_addr) >= TAPS);

  // Offset by TAPS before subtracting so the modulo also holds for non-power-of-two TAPS.
  always_comb begin
    idx_sum = {1'b0, wr_ptr_q} + (AW + 1)'(TAPS) - {1'b0, k_q};
    tap_idx = (idx_sum >= (AW + 1)'(TAPS)) ? AW'(idx_sum - (AW + 1)'(TAPS)) : AW'(idx_sum);
  end

  fir_coef_bank #(
    .CW    (CW),
    .TAPS  (TAPS),
    .NBANK (NBANK)
  ) u_coef (
    .clk     (clk),
    .rst     (rst),
    .we      (coef_we & ~coef_rej),
    .wr_bank (coef_bank),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_bank (act_bank_q),
    .rd_idx  (k_q),
    .rd_data (coef_rd)
  );

  always_comb begin
    x_tap   = dline_q[tap_idx];
    prod    = (DW + CW)'(x_tap) * (DW + CW)'(coef_rd);
    rnd_sum = (ACCW + 1)'(acc_q) + RND;
    shifted = rnd_sum >>> SH;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wr_ptr_d     = wr_ptr_q;
    act_bank_d   = act_bank_q;
    acc_d        = acc_q;
    dline_d      = dline_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    coef_nack_d  = coef_we & coef_rej;
    overrun_d    = overrun_q | (rise & busy);
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          dline_d[wr_ptr_q] = din;
          act_bank_d        = bank_sel;
          acc_d             = '0;
          k_d               = '0;
          state_d           = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (k_q == AW'(TAPS - 1)) state_d = OUT;
        else k_d = k_q + 1'b1;
      end
      OUT: begin
        dout_d       = DW'(sat(longint'(shifted), DW));
        dout_valid_d = 1'b1;
        wr_ptr_d     = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_meta_q    <= 1'b0;
      fs_sync_q    <= 1'b0;
      fs_prev_q    <= 1'b0;
      state_q      <= IDLE;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      act_bank_q   <= '0;
      acc_q        <= '0;
      dline_q      <= '{default: '0};
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      coef_nack_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      fs_meta_q    <= f_s;
      fs_sync_q    <= fs_meta_q;
      fs_prev_q    <= fs_sync_q;
      state_q      <= state_d;
      k_q          <= k_d;
      wr_ptr_q     <= wr_ptr_d;
      act_bank_q   <= act_bank_d;
      acc_q        <= acc_d;
      dline_q      <= dline_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      coef_nack_q  <= coef_nack_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign coef_nack  = coef_nack_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: behavioural sample-history model plus literal pins.
module tb_fir_mac_filter;

  localparam int DW    = 12;
  localparam int CW    = 16;
  localparam int TAPS  = 32;
  localparam int NBANK = 2;
  localparam int BW    = 1;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 f_s = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic [BW-1:0]        bank_sel = '0;
  logic                 coef_we = 1'b0;
  logic [BW-1:0]        coef_bank = '0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_valid, busy, coef_nack, overrun;

  fir_mac_filter #(
    .DW    (DW),
    .CW    (CW),
    .TAPS  (TAPS),
    .NBANK (NBANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .f_s        (f_s),
    .din        (din),
    .bank_sel   (bank_sel),
    .coef_we    (coef_we),
    .coef_bank  (coef_bank),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .coef_nack  (coef_nack),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_nack = 0;
  bit chk_en = 1'b0;
  int got[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of captured samples (xs[0] newest) and a coefficient table.
  int     mc [NBANK][TAPS];
  int     xs [TAPS];
  bit     fh [3];
  int     busy_left;
  int     m_act;
  longint pend;
  longint e_dout;
  bit     e_valid, e_nack, e_over;
  bit     m_rise, m_busy_now, m_rej;

  function automatic longint filt(input int b);
    longint a;
    a = 0;
    for (int k = 0; k < TAPS; k++) a += longint'(xs[k]) * longint'(mc[b][k]);
    a = (a + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    if (a > 2047) a = 2047;
    if (a < -2048) a = -2048;
    return a;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) for (int k = 0; k < TAPS; k++) mc[b][k] = 0;
      for (int k = 0; k < TAPS; k++) xs[k] = 0;
      fh[0] = 0; fh[1] = 0; fh[2] = 0;
      busy_left = 0; m_act = 0; pend = 0;
      e_dout = 0; e_valid = 0; e_nack = 0; e_over = 0;
    end else begin
      m_rise     = fh[1] && !fh[2];
      m_busy_now = (busy_left > 0);
      e_nack = 0;
      if (coef_we) begin
        m_rej = (m_busy_now && int'(coef_bank) == m_act) ||
                int'(coef_bank) >= NBANK || int'(coef_addr) >= TAPS;
        if (m_rej) e_nack = 1;
        else mc[coef_bank][coef_addr] = int'(coef_data);
      end
      e_valid = 0;
      if (m_busy_now) begin
        if (m_rise) e_over = 1;
        busy_left--;
        if (busy_left == 0) begin
          e_dout  = pend;
          e_valid = 1;
        end
      end else if (m_rise) begin
        for (int k = TAPS - 1; k > 0; k--) xs[k] = xs[k-1];
        xs[0]     = int'(din);
        m_act     = int'(bank_sel);
        pend      = filt(m_act);
        busy_left = TAPS + 1;
      end
      fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = f_s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", longint'(dout), e_dout);
      chk("dout_valid", longint'(dout_valid), longint'(e_valid));
      chk("busy", longint'(busy), longint'(busy_left > 0));
      chk("coef_nack", longint'(coef_nack), longint'(e_nack));
      chk("overrun", longint'(overrun), longint'(e_over));
      if (dout_valid) begin
        got.push_back(int'(dout));
        n_valid++;
      end
      if (coef_nack) n_nack++;
    end
  end

  task automatic wr_coef(input int b, input int a, input int d);
    @(negedge clk);
    coef_we = 1'b1; coef_bank = BW'(b); coef_addr = AW'(a); coef_data = CW'(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send_sample(input int d, input int gap);
    @(negedge clk);
    din = DW'(d); f_s = 1'b1;
    repeat (3) @(negedge clk);
    f_s = 1'b0;
    repeat (gap - 3) @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < TAPS; k++) wr_coef(0, k, k * 100);
  endtask

  task automatic run_impulse(input string tag);
    got.delete();
    send_sample(2047, 40);
    for (int n = 1; n <= TAPS; n++) send_sample(0, 40);
    chk({tag, "_count"}, got.size(), TAPS + 1);
    if (got.size() == TAPS + 1) begin
      chk({tag, "_k0"}, got[0], 0);
      chk({tag, "_k1"}, got[1], 6);
      chk({tag, "_k16"}, got[16], 100);
      chk({tag, "_k31"}, got[31], 194);
      chk({tag, "_tail"}, got[32], 0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv0, nn0, i;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(overrun), 0);

    load_ramp();
    run_impulse("impulse");

    // Bank switch mid-MAC and rejected write to the active bank.
    wr_coef(0, 0, 16384);
    for (int k = 1; k < TAPS; k++) wr_coef(1, k, -k * 100);
    wr_coef(1, 0, -16384);
    got.delete();
    bank_sel = 1'b0;
    @(negedge clk);
    din = 12'sd2047; f_s = 1'b1;
    repeat (3) @(negedge clk);
    f_s = 1'b0;
    repeat (7) @(negedge clk);
    bank_sel = 1'b1;
    nn0 = n_nack;
    wr_coef(0, 2, 7777);
    @(negedge clk);
    chk("nack_count", n_nack - nn0, 1);
    repeat (30) @(negedge clk);
    send_sample(0, 40);
    bank_sel = 1'b0;
    send_sample(0, 40);
    chk("bank_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bank_cur_uses_b0", got[0], 1024);
      chk("bank_next_uses_b1", got[1], -6);
      chk("bank_coef_kept", got[2], 12);
    end

    // DC step through an LPF bank.
    for (int k = 0; k < TAPS; k++) wr_coef(0, k, 1024);
    got.delete();
    for (int n = 0; n < TAPS + 1; n++) send_sample(1000, 40);
    if (got.size() > 0) chk("dc_settle", got[got.size()-1], 1000);
    else chk("dc_count", 0, TAPS + 1);

    // Saturation both directions.
    for (int k = 0; k < TAPS; k++) wr_coef(0, k, 32767);
    got.delete();
    for (int n = 0; n < 4; n++) send_sample(2047, 40);
    if (got.size() > 0) chk("sat_pos", got[got.size()-1], 2047);
    else chk("sat_pos_count", 0, 4);
    got.delete();
    for (int n = 0; n < 20; n++) send_sample(-2048, 40);
    if (got.size() > 0) chk("sat_neg", got[got.size()-1], -2048);
    else chk("sat_neg_count", 0, 20);

    // Random samples, bank selects and coefficient traffic.
    for (int s = 0; s < 40; s++) begin
      int gap;
      gap = $urandom_range(TAPS + 5, TAPS + 12);
      @(negedge clk);
      din = DW'($urandom); bank_sel = BW'($urandom_range(0, NBANK - 1)); f_s = 1'b1;
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        if (c == 2) f_s = 1'b0;
        coef_we   = ($urandom_range(0, 2) == 0);
        coef_bank = BW'($urandom_range(0, NBANK - 1));
        coef_addr = AW'($urandom);
        coef_data = CW'(int'($urandom_range(0, 8191)) - 4096);
      end
      coef_we = 1'b0;
    end

    // Overrun: second edge 10 cycles after the first is dropped.
    nv0 = n_valid;
    @(negedge clk);
    din = 12'sd500; f_s = 1'b1;
    repeat (3) @(negedge clk);
    f_s = 1'b0;
    repeat (7) @(negedge clk);
    din = 12'sd300; f_s = 1'b1;
    repeat (3) @(negedge clk);
    f_s = 1'b0;
    repeat (50) @(negedge clk);
    chk("overrun_set", longint'(overrun), 1);
    chk("overrun_one_valid", n_valid - nv0, 1);

    // Reset in the middle of a computation.
    @(negedge clk);
    din = 12'sd1234; f_s = 1'b1;
    i = 0;
    while (!busy && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("wait_busy", longint'(busy), 1);
    f_s = 1'b0;
    repeat (9) @(negedge clk);
    nv0 = n_valid;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_dout", longint'(dout), 0);
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_overrun", longint'(overrun), 0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_valid", n_valid - nv0, 0);
    load_ramp();
    run_impulse("impulse_after_rst");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
